bank_scheduler_response_queue: RTL and testbench

Per-bank response buffer between the physical memory model and the bank scheduler's response port. It captures memory responses (address, data, request ID), which cannot be back-pressured, into a FIFO and presents them in order on a valid/ready port. It provides the global cycle counter and the `resp_fire` strobe consumed by the per-bank response statistics logger. It also keeps occupancy, high-water-mark and drop statistics.

---
 rtl/bank_scheduler_response_queue_if.sv | 24 ++
 rtl/bank_scheduler_response_queue.sv | 111 +++++++++++
 tb/tb_bank_scheduler_response_queue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bank_scheduler_response_queue_if.sv
// Response-path signal bundle: memory-side capture inputs and the valid/ready head port.
// The queue connects through the slave modport; the memory model and consumer use master.
interface bank_scheduler_response_queue_if;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_addr;
    logic [31:0] mem_resp_data;
    logic [31:0] mem_resp_id;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_addr;
    logic [31:0] resp_data;
    logic [31:0] resp_id;
    logic        resp_fire;

    modport master (
        output mem_resp_valid, mem_resp_addr, mem_resp_data, mem_resp_id, resp_ready,
        input  resp_valid, resp_addr, resp_data, resp_id, resp_fire
    );

    modport slave (
        input  mem_resp_valid, mem_resp_addr, mem_resp_data, mem_resp_id, resp_ready,
        output resp_valid, resp_addr, resp_data, resp_id, resp_fire
    );
endinterface

// File: rtl/bank_scheduler_response_queue.sv
// Per-bank response FIFO: captures unstallable memory responses, serves them in order on a
// valid/ready port, and keeps cycle, occupancy, high-water and drop statistics.
module bank_scheduler_response_queue #(
    parameter int RANK  = 0,
    parameter int BANK  = 0,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    bank_scheduler_response_queue_if.slave bus,
    output logic [63:0]              global_cycle,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   max_count,
    output logic [31:0]              drop_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RANK < 0 || BANK < 0) begin : g_bad_cfg
        $error("bank_scheduler_response_queue: DEPTH must be a power of two >= 2, RANK/BANK >= 0");
    end

    logic [31:0]   r_addr_mem [DEPTH];
    logic [31:0]   r_data_mem [DEPTH];
    logic [31:0]   r_id_mem   [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_max_count;
    logic [31:0]   r_drop_count;
    logic          r_overflow;
    logic [63:0]   r_global_cycle;

    logic          w_valid;
    logic          w_full;
    logic          w_fire;
    logic          w_enq;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_fire  = w_valid && bus.resp_ready;
    // A dequeue in the same cycle frees the slot, so a full queue still accepts.
    assign w_enq   = bus.mem_resp_valid && (!w_full || w_fire);
    assign w_drop  = bus.mem_resp_valid && w_full && !w_fire;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_enq, w_fire})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_max_count    <= '0;
            r_drop_count   <= '0;
            r_overflow     <= 1'b0;
            r_global_cycle <= '0;
        end else begin
            r_global_cycle <= r_global_cycle + 64'd1;
            r_count        <= w_count_nxt;
            if (w_count_nxt > r_max_count) begin
                r_max_count <= w_count_nxt;
            end
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + 32'd1;
                end
            end
        end
    end

    // Storage is deliberately left unreset; head fields are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr_mem[r_wr_ptr] <= bus.mem_resp_addr;
            r_data_mem[r_wr_ptr] <= bus.mem_resp_data;
            r_id_mem[r_wr_ptr]   <= bus.mem_resp_id;
        end
    end

    assign bus.resp_valid = w_valid;
    assign bus.resp_fire  = w_fire;
    assign bus.resp_addr  = r_addr_mem[r_rd_ptr];
    assign bus.resp_data  = r_data_mem[r_rd_ptr];
    assign bus.resp_id    = r_id_mem[r_rd_ptr];

    assign global_cycle = r_global_cycle;
    assign full         = w_full;
    assign count        = r_count;
    assign max_count    = r_max_count;
    assign drop_count   = r_drop_count;
    assign overflow     = r_overflow;
endmodule

// File: tb/tb_bank_scheduler_response_queue.sv
// Directed bench for bank_scheduler_response_queue (DEPTH=8) with hand-computed expectations.
module tb_bank_scheduler_response_queue;
    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic [63:0] global_cycle;
    logic        full;
    logic [3:0]  count;
    logic [3:0]  max_count;
    logic [31:0] drop_count;
    logic        overflow;

    int unsigned n_pass;
    int unsigned n_total;

    bank_scheduler_response_queue_if bus ();

    bank_scheduler_response_queue #(
        .RANK  (0),
        .BANK  (0),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .global_cycle (global_cycle),
        .full         (full),
        .count        (count),
        .max_count    (max_count),
        .drop_count   (drop_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [31:0] id, input logic [31:0] addr, input logic [31:0] data);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_id    = id;
        bus.mem_resp_addr  = addr;
        bus.mem_resp_data  = data;
    endtask

    initial begin
        logic [19:0] pat;
        int unsigned idx;
        logic        exp_valid;
        logic        exp_fire;

        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_addr  = '0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_id    = '0;
        bus.resp_ready     = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_valid", bus.resp_valid, 0);
        check("rst_full", full, 0);
        check("rst_gcycle", global_cycle, 0);
        reset = 1'b0;
        check("gcycle_first", global_cycle, 0);
        tick();
        check("gcycle_one", global_cycle, 1);

        // Single response
        do_reset();
        bus.resp_ready = 1'b1;
        send(7, 32'h40, 32'hDEAD);
        #1;
        check("single_nobypass", bus.resp_valid, 0);
        check("single_nofire", bus.resp_fire, 0);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("single_valid", bus.resp_valid, 1);
        check("single_addr", bus.resp_addr, 32'h40);
        check("single_data", bus.resp_data, 32'hDEAD);
        check("single_id", bus.resp_id, 7);
        check("single_fire", bus.resp_fire, 1);
        check("single_count1", count, 1);
        tick();
        check("single_valid0", bus.resp_valid, 0);
        check("single_fire0", bus.resp_fire, 0);
        check("single_count0", count, 0);
        check("single_max", max_count, 1);

        // Fill to full with 10 responses, 2 dropped
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(i, i * 4, i + 32'h100);
            tick();
            if (i == 6) check("fill_notfull7", full, 0);
            if (i == 7) begin
                check("fill_full8", full, 1);
                check("fill_count8", count, 8);
            end
        end
        bus.mem_resp_valid = 1'b0;
        #1;
        check("fill_drop", drop_count, 2);
        check("fill_ovf", overflow, 1);
        check("fill_max", max_count, 8);
        check("fill_head", bus.resp_id, 0);

        // Full with simultaneous enqueue and dequeue
        bus.resp_ready = 1'b1;
        send(99, 32'h400, 32'h999);
        #1;
        check("simul_fire", bus.resp_fire, 1);
        check("simul_full", full, 1);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("simul_count", count, 8);
        check("simul_drop", drop_count, 2);
        for (int i = 1; i < 8; i++) begin
            check("drain_id", bus.resp_id, i);
            check("drain_addr", bus.resp_addr, i * 4);
            tick();
        end
        check("drain_id99", bus.resp_id, 99);
        check("drain_data99", bus.resp_data, 32'h999);
        tick();
        check("drain_empty", bus.resp_valid, 0);
        check("drain_count0", count, 0);

        // Back-pressure stability over a fixed ready pattern
        do_reset();
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(200 + i, (200 + i) * 4, 32'hB000 + i);
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        pat = 20'b1100_1010_0110_1101_0010;
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            bus.resp_ready = pat[i];
            #1;
            exp_valid = (idx < 3);
            exp_fire  = exp_valid && pat[i];
            check("bp_valid", bus.resp_valid, exp_valid);
            check("bp_fire", bus.resp_fire, exp_fire);
            if (exp_valid) begin
                check("bp_id", bus.resp_id, 200 + idx);
                check("bp_addr", bus.resp_addr, (200 + idx) * 4);
                check("bp_data", bus.resp_data, 32'hB000 + idx);
            end
            tick();
            if (exp_fire) idx++;
        end
        check("bp_count0", count, 0);
        check("bp_drop0", drop_count, 0);

        // Reset mid-operation: 5 entries queued with 3 drops
        do_reset();
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            send(i, i, i);
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.resp_ready = 1'b0;
        #1;
        check("mid_pre_count", count, 5);
        check("mid_pre_drop", drop_count, 3);
        bus.resp_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("mid_count", count, 0);
        check("mid_valid", bus.resp_valid, 0);
        check("mid_fire", bus.resp_fire, 0);
        check("mid_full", full, 0);
        check("mid_max", max_count, 0);
        check("mid_drop", drop_count, 0);
        check("mid_ovf", overflow, 0);
        check("mid_gcycle", global_cycle, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_gcycle_rel", global_cycle, 0);
        tick();
        check("mid_gcycle_1", global_cycle, 1);

        // Pointer wrap: 3*DEPTH back-to-back with ready held high
        do_reset();
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            send(300 + k, k * 4, ~k);
            tick();
            check("wrap_valid", bus.resp_valid, 1);
            check("wrap_id", bus.resp_id, 300 + k);
            check("wrap_count", count, 1);
        end
        bus.mem_resp_valid = 1'b0;
        tick();
        check("wrap_empty", bus.resp_valid, 0);
        check("wrap_count0", count, 0);
        check("wrap_max", max_count, 1);
        check("wrap_drop", drop_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
